// File: rtl/xcvr_loopback_seq.sv
// rtl/xcvr_loopback_seq.sv - loopback test sequencer: lane ready, startup gating, lock wait, timed error window
// Optional build macro XCVR_SEQ_SOAK_EN: RUN lasts until start_i drops; adds soak_cycles_o.
module xcvr_loopback_seq #(
    parameter int STARTUP_DLY  = 9,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int TEST_LEN     = 65536,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 tx_clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 lane_ready_i,
    input  logic                 chk_locked_i,
    input  logic                 chk_error_i,
    output logic                 gen_en_o,
    output logic                 chk_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [1:0]           fail_code_o,
    output logic [ERR_CNT_W-1:0] err_count_o
`ifdef XCVR_SEQ_SOAK_EN
    ,
    output logic [31:0]          soak_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_STARTUP,
        S_WAIT_LOCK,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0] DLY_LAST  = 32'(STARTUP_DLY - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] LEN_LAST  = 32'(TEST_LEN - 1);

    localparam logic [1:0] FC_OK       = 2'd0;
    localparam logic [1:0] FC_LOCK_TO  = 2'd1;
    localparam logic [1:0] FC_LANE     = 2'd2;
    localparam logic [1:0] FC_LOCKLOST = 2'd3;

    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [1:0]            fail_q, fail_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  pass_q, pass_d;
    logic [31:0]           soak_q, soak_d;

    always_ff @(posedge tx_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            soak_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            soak_q  <= soak_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        fail_d  = fail_q;
        err_d   = err_q;
        pass_d  = pass_q;
        soak_d  = soak_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = S_WAIT_READY;
                    fail_d  = FC_OK;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    soak_d  = '0;
                end
            end
            S_WAIT_READY: begin
                cnt_d = '0;
                if (lane_ready_i) state_d = S_STARTUP;
            end
            S_STARTUP: begin
                if (!lane_ready_i) begin
                    state_d = S_DONE;
                    fail_d  = FC_LANE;
                end else if (cnt_q == DLY_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (!lane_ready_i) begin
                    state_d = S_DONE;
                    fail_d  = FC_LANE;
                end else if (chk_locked_i) begin
                    state_d = S_RUN;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_DONE;
                    fail_d  = FC_LOCK_TO;
                end
            end
            S_RUN: begin
                // The error on the terminating cycle still counts.
                if (chk_error_i && (err_q != {ERR_CNT_W{1'b1}})) err_d = err_q + 1'b1;
                if (soak_q != 32'hFFFF_FFFF) soak_d = soak_q + 32'd1;
                if (!lane_ready_i) begin
                    state_d = S_DONE;
                    fail_d  = FC_LANE;
                end else if (!chk_locked_i) begin
                    state_d = S_DONE;
                    fail_d  = FC_LOCKLOST;
`ifdef XCVR_SEQ_SOAK_EN
                end else if (!start_i) begin
`else
                end else if (cnt_q == LEN_LAST) begin
`endif
                    state_d = S_DONE;
                    fail_d  = FC_OK;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Every state entry restarts the shared delay/timeout/window counter.
        if (state_d != state_q) cnt_d = '0;
        if ((state_d == S_DONE) && (state_q != S_DONE))
            pass_d = (fail_d == FC_OK) && (err_d == '0);
    end

    always_comb begin
        gen_en_o = 1'b0;
        chk_en_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_WAIT_READY: busy_o = 1'b1;
            S_STARTUP: begin
                busy_o   = 1'b1;
                gen_en_o = 1'b1;
            end
            S_WAIT_LOCK, S_RUN: begin
                busy_o   = 1'b1;
                gen_en_o = 1'b1;
                chk_en_o = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign pass_o      = pass_q;
    assign fail_code_o = fail_q;
    assign err_count_o = err_q;
`ifdef XCVR_SEQ_SOAK_EN
    assign soak_cycles_o = soak_q;
`endif

endmodule

// File: tb/tb_xcvr_loopback_seq.sv
// tb/tb_xcvr_loopback_seq.sv - scoreboard bench for xcvr_loopback_seq (16-bit and 4-bit error counters)
module tb_xcvr_loopback_seq;

    localparam int SD = 9;
    localparam int LT = 64;
    localparam int TL = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, lane = 1'b0, lock = 1'b0, err = 1'b0;

    logic gen_en, chk_en, busy, done, pass;
    logic [1:0] fc;
    logic [15:0] ec;
    logic s_gen_en, s_chk_en, s_busy, s_done, s_pass;
    logic [1:0] s_fc;
    logic [3:0] s_ec;

    xcvr_loopback_seq #(.STARTUP_DLY(SD), .LOCK_TIMEOUT(LT), .TEST_LEN(TL), .ERR_CNT_W(16)) dut (
        .tx_clk_i(clk), .reset_i(rst), .start_i(start), .lane_ready_i(lane),
        .chk_locked_i(lock), .chk_error_i(err), .gen_en_o(gen_en), .chk_en_o(chk_en),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_code_o(fc), .err_count_o(ec)
    );

    xcvr_loopback_seq #(.STARTUP_DLY(SD), .LOCK_TIMEOUT(LT), .TEST_LEN(TL), .ERR_CNT_W(4)) dut_s (
        .tx_clk_i(clk), .reset_i(rst), .start_i(start), .lane_ready_i(lane),
        .chk_locked_i(lock), .chk_error_i(err), .gen_en_o(s_gen_en), .chk_en_o(s_chk_en),
        .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .fail_code_o(s_fc), .err_count_o(s_ec)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  fc;
        logic [15:0] ec;
        logic [3:0]  ecs;
        logic        pass;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: each rising done_o retires one expected result.
    logic done_prev = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("fail_code", int'(fc), int'(e.fc));
                check("err_count", int'(ec), int'(e.ec));
                check("err_count_sat", int'(s_ec), int'(e.ecs));
                check("pass", int'(pass), int'(e.pass));
                check("sat_pass", int'(s_pass), int'(e.pass));
                check("done_gen_en", int'(gen_en), 0);
                check("done_chk_en", int'(chk_en), 0);
                check("done_busy", int'(busy), 0);
                check("sat_done", int'(s_done), 1);
            end
        end
        done_prev = done;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_run;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_chk_en(output int n);
        n = 0;
        while (!chk_en && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) check("chk_en_wait_timeout", 0, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            tick(1);
            n++;
        end
        if (n >= 400) check("done_wait_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tick(2);
        check("rst_gen_en", int'(gen_en), 0);
        check("rst_chk_en", int'(chk_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_fail_code", int'(fc), 0);
        check("rst_err_count", int'(ec), 0);
        rst  = 1'b0;
        lane = 1'b1;
        tick(1);

        // Nominal run
        begin_run;
        tick(1);
        check("startup_gen_en", int'(gen_en), 1);
        check("startup_chk_en", int'(chk_en), 0);
        wait_chk_en(n);
        check("chk_en_delay", n, SD);
        tick(5);
        lock = 1'b1;
        exp_q.push_back('{fc: 2'd0, ec: 16'd0, ecs: 4'd0, pass: 1'b1});
        wait_done(n);
        check("run_length", n, TL + 1);
        lock = 1'b0;

        // Errors: two ignored in WAIT_LOCK, three counted in RUN
        begin_run;
        wait_chk_en(n);
        check("chk_en_delay_from_start", n, SD + 1);
        err = 1'b1; tick(1); err = 1'b0; tick(1);
        err = 1'b1; tick(1); err = 1'b0;
        lock = 1'b1;
        tick(1);
        repeat (3) begin
            err = 1'b1; tick(1); err = 1'b0; tick(2);
        end
        exp_q.push_back('{fc: 2'd0, ec: 16'd3, ecs: 4'd3, pass: 1'b0});
        wait_done(n);
        lock = 1'b0;

        // Lock timeout
        begin_run;
        wait_chk_en(n);
        exp_q.push_back('{fc: 2'd1, ec: 16'd0, ecs: 4'd0, pass: 1'b0});
        wait_done(n);
        check("lock_timeout_len", n, LT);

        // Lane loss at RUN cycle 40 together with lock loss
        begin_run;
        wait_chk_en(n);
        lock = 1'b1;
        tick(1);
        tick(39);
        lane = 1'b0;
        lock = 1'b0;
        exp_q.push_back('{fc: 2'd2, ec: 16'd0, ecs: 4'd0, pass: 1'b0});
        tick(1);
        check("lane_loss_done", int'(done), 1);
        begin_run;
        tick(3);
        check("wait_ready_busy", int'(busy), 1);
        check("wait_ready_gen_en", int'(gen_en), 0);
        check("wait_ready_done", int'(done), 0);

        // Saturation: error held through the whole RUN window
        lane = 1'b1;
        wait_chk_en(n);
        err  = 1'b1;
        lock = 1'b1;
        exp_q.push_back('{fc: 2'd0, ec: 16'd100, ecs: 4'd15, pass: 1'b0});
        wait_done(n);
        err  = 1'b0;
        lock = 1'b0;
        tick(1);

        // Back-to-back runs with start held high
        start = 1'b1;
        lock  = 1'b1;
        exp_q.push_back('{fc: 2'd0, ec: 16'd0, ecs: 4'd0, pass: 1'b1});
        exp_q.push_back('{fc: 2'd0, ec: 16'd0, ecs: 4'd0, pass: 1'b1});
        tick(1);
        wait_done(n);
        tick(1);
        check("b2b_single_done_cycle", int'(done), 0);
        check("b2b_busy_again", int'(busy), 1);
        start = 1'b0;
        wait_done(n);
        lock = 1'b0;
        tick(1);

        // Asynchronous reset in RUN
        begin_run;
        wait_chk_en(n);
        lock = 1'b1;
        tick(10);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gen_en", int'(gen_en), 0);
        check("async_rst_chk_en", int'(chk_en), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sat_busy", int'(s_busy), 0);
        tick(1);
        rst  = 1'b0;
        lock = 1'b0;
        tick(2);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);
        check("post_rst_err", int'(ec), 0);
        check("post_rst_gen_en", int'(gen_en), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
